// File: rtl/if_stage_pkg.sv
// Shared constants and PC helpers for the fetch stage.
package if_stage_pkg;

  localparam int               INSTR_W      = 32;
  localparam logic [INSTR_W-1:0] PC_INC       = 32'd4;
  localparam logic [INSTR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [INSTR_W-1:0] DEF_NOP      = 32'h0000_0000;

  function automatic logic [INSTR_W-1:0] pc_incr(input logic [INSTR_W-1:0] a);
    return a + PC_INC;
  endfunction

  function automatic logic [INSTR_W-1:0] pc_align(input logic [INSTR_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select: redirect beats stall beats increment.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= pc_align(redirect_pc);
    else if (!stall)
      pc <= pc_incr(pc);
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: drives imem from the PC and captures {pc, pc+4, instr} into IF/ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] pc_out,
  output logic [INSTR_W-1:0] pc_plus4_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  logic [INSTR_W-1:0] pc_p0;
  logic [INSTR_W-1:0] pc4_p0;
  logic [INSTR_W-1:0] pc_p1;
  logic [INSTR_W-1:0] pc4_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc_p0)
  );

  assign pc4_p0    = pc_incr(pc_p0);
  assign imem_addr = pc_p0;

  // IF -> ID boundary: flush beats stall beats capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p1    <= '0;
      pc4_p1   <= '0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      pc_p1    <= '0;
      pc4_p1   <= '0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (!stall) begin
      pc_p1    <= pc_p0;
      pc4_p1   <= pc4_p0;
      instr_p1 <= imem_rdata;
      vld_p1   <= 1'b1;
    end
  end

  assign pc_out       = pc_p1;
  assign pc_plus4_out = pc4_p1;
  assign instr_out    = instr_p1;
  assign valid_out    = vld_p1;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model checked every cycle plus directed literal checks.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [31:0] instr_out;
  logic        valid_out;

  logic [31:0] key;
  int          checks = 0;
  int          errors = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_out        (pc_out),
    .pc_plus4_out  (pc_plus4_out),
    .instr_out     (instr_out),
    .valid_out     (valid_out)
  );

  always #5 clk = ~clk;

  // Instruction memory: the word at an address is the address XOR a selectable key.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] k);
    return a ^ k;
  endfunction

  assign imem_rdata = mem_word(imem_addr, key);

  // Reference model: fetch address plus the expected contents of IF/ID.
  logic [31:0] m_pc, m_pc_out, m_pc4_out, m_instr;
  logic        m_valid;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc      <= 32'h0;
      m_pc_out  <= 32'h0;
      m_pc4_out <= 32'h0;
      m_instr   <= 32'h0;
      m_valid   <= 1'b0;
    end else begin
      if (flush) begin
        m_pc_out  <= 32'h0;
        m_pc4_out <= 32'h0;
        m_instr   <= 32'h0;
        m_valid   <= 1'b0;
      end else if (!stall) begin
        m_pc_out  <= m_pc;
        m_pc4_out <= m_pc + 32'd4;
        m_instr   <= mem_word(m_pc, key);
        m_valid   <= 1'b1;
      end
      if (redirect_valid)
        m_pc <= {redirect_pc[31:2], 2'b00};
      else if (!stall)
        m_pc <= m_pc + 32'd4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model imem_addr", imem_addr, m_pc);
      chk("model pc_out", pc_out, m_pc_out);
      chk("model pc_plus4_out", pc_plus4_out, m_pc4_out);
      chk("model instr_out", instr_out, m_instr);
      chk("model valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] t);
    stall          = s;
    flush          = f;
    redirect_valid = r;
    redirect_pc    = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    key = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    cyc();
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset instr_out", instr_out, 32'h0);
    chk("reset valid_out", {31'b0, valid_out}, 32'h0);
    rst = 1'b1;
    #2;
    chk("first cycle valid_out", {31'b0, valid_out}, 32'h0);

    // Straight-line fetch, address-as-data
    cyc();
    chk("t1 instr0", instr_out, 32'h0);
    chk("t1 valid", {31'b0, valid_out}, 32'h1);
    chk("t1 imem_addr", imem_addr, 32'h4);
    cyc();
    chk("t1 instr4", instr_out, 32'h4);
    chk("t1 pc4 of 4", pc_plus4_out, 32'h8);
    cyc();
    chk("t1 instr8", instr_out, 32'h8);
    cyc();
    chk("t1 instrC", instr_out, 32'hC);
    chk("t1 pc at 0x10", imem_addr, 32'h10);

    // Stall three cycles at PC 0x10
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2 stall imem_addr", imem_addr, 32'h10);
      chk("t2 stall instr hold", instr_out, 32'hC);
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    chk("t2 resume instr", instr_out, 32'h10);
    chk("t2 resume imem_addr", imem_addr, 32'h14);

    // Redirect with flush; misaligned target gets aligned
    key = 32'h1234_0000;
    set_in(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3 imem_addr", imem_addr, 32'h100);
    chk("t3 bubble valid", {31'b0, valid_out}, 32'h0);
    chk("t3 bubble instr", instr_out, 32'h0);
    cyc();
    chk("t3 target instr", instr_out, 32'h1234_0100);
    chk("t3 target valid", {31'b0, valid_out}, 32'h1);

    // Redirect without flush: delay-slot instruction still captured
    set_in(1'b0, 1'b0, 1'b1, 32'h40);
    cyc();
    chk("t4 delay slot pc_out", pc_out, 32'h104);
    chk("t4 delay slot valid", {31'b0, valid_out}, 32'h1);
    chk("t4 pc at 0x40", imem_addr, 32'h40);
    // Stall, flush and redirect together: stall ignored
    set_in(1'b1, 1'b1, 1'b1, 32'h80);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4 imem_addr", imem_addr, 32'h80);
    chk("t4 bubble valid", {31'b0, valid_out}, 32'h0);
    cyc();
    chk("t4 pc_out target", pc_out, 32'h80);

    // Wrap of PC+4 at the top of the address space
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cyc();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5 imem_addr top", imem_addr, 32'hFFFF_FFFC);
    cyc();
    chk("t5 imem_addr wrap", imem_addr, 32'h0);
    chk("t5 pc_out", pc_out, 32'hFFFF_FFFC);
    chk("t5 pc_plus4 wrap", pc_plus4_out, 32'h0);

    // Async reset mid-cycle with a redirect pending
    cyc();
    cyc();
    set_in(1'b0, 1'b0, 1'b1, 32'h200);
    #2;
    rst = 1'b0;
    #1;
    chk("t6 async imem_addr", imem_addr, 32'h0);
    chk("t6 async pc_out", pc_out, 32'h0);
    chk("t6 async pc_plus4", pc_plus4_out, 32'h0);
    chk("t6 async instr", instr_out, 32'h0);
    chk("t6 async valid", {31'b0, valid_out}, 32'h0);
    cyc();
    chk("t6 held imem_addr", imem_addr, 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    cyc();
    chk("t6 restart pc_out", pc_out, 32'h0);
    chk("t6 restart imem_addr", imem_addr, 32'h4);
    chk("t6 restart valid", {31'b0, valid_out}, 32'h1);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
